// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/debounce filter.
package sync_pkg;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int DEF_FILTER = 4;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/sync_filter_ch.sv
// One channel: CDC flop chain, persistence counter, debounced level and edge pulses.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   STAGES    = DEF_STAGES,
    parameter int   FILTER    = DEF_FILTER,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    input  logic hold,
    output logic out,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam int            CW      = clog2(FILTER);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic              s;

    assign s = chain[STAGES-1];
    // New level has persisted FILTER cycles; take it at this edge.
    assign accept = !hold && (s != out) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= {STAGES{RESET_VAL}};
        else        chain <= {chain[STAGES-2:0], in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= RESET_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & s;
            fall <= accept & ~s;
            if (!hold) begin
                if (s == out || accept) cnt <= '0;
                else                    cnt <= cnt + CW'(1);
                if (accept) out <= s;
            end
        end
    end
endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchronizer with per-channel persistence filter and edge reporting.
module sync_filter
    import sync_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STAGES    = DEF_STAGES,
    parameter int               FILTER    = DEF_FILTER,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             hold,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES   (STAGES),
            .FILTER   (FILTER),
            .RESET_VAL(RESET_VAL[i])
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (in[i]),
            .hold  (hold),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .accept(accept[i])
        );
    end

    // Registered alongside rise/fall so it lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) changed <= 1'b0;
        else        changed <= |accept;
    end
endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter against a queue-based behavioural model.
module tb_sync_filter;
    localparam int         W    = 8;
    localparam int         ST   = 2;
    localparam int         F    = 4;
    localparam logic [7:0] RV_B = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, hold, hold_b;
    logic [W-1:0] in, in_b;
    logic [W-1:0] out, rise, fall;
    logic         changed;
    logic [W-1:0] out_b, rise_b, fall_b;
    logic         changed_b;

    int checks = 0;
    int errors = 0;

    sync_filter #(.WIDTH(W), .STAGES(ST), .FILTER(F), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .hold(hold),
        .out(out), .rise(rise), .fall(fall), .changed(changed)
    );

    sync_filter #(.WIDTH(W), .STAGES(ST), .FILTER(F), .RESET_VAL(RV_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .hold(hold_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
    );

    // Model: a delay line of sampled inputs, plus a run length of consecutive
    // non-held cycles on which the synchronized level disagreed with out.
    logic [W-1:0] q_in[$];
    logic [W-1:0] m_out, m_rise, m_fall;
    logic         m_chg;
    int           run[W];

    function automatic void model_reset();
        q_in.delete();
        for (int k = 0; k < ST; k++) q_in.push_back('0);
        m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        for (int i = 0; i < W; i++) run[i] = 0;
    endfunction

    function automatic void model_edge();
        logic [W-1:0] s;
        s = q_in.pop_front();
        q_in.push_back(in);
        m_rise = '0; m_fall = '0;
        if (!hold) begin
            for (int i = 0; i < W; i++) begin
                if (s[i] != m_out[i]) begin
                    run[i]++;
                    if (run[i] == F) begin
                        m_out[i] = s[i];
                        run[i] = 0;
                        if (s[i]) m_rise[i] = 1'b1;
                        else      m_fall[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
        m_chg = |(m_rise | m_fall);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        checks++;
        if (out !== m_out) begin errors++; $display("FAIL model_out: got %h expected %h t=%0t", out, m_out, $time); end
        checks++;
        if (rise !== m_rise) begin errors++; $display("FAIL model_rise: got %h expected %h t=%0t", rise, m_rise, $time); end
        checks++;
        if (fall !== m_fall) begin errors++; $display("FAIL model_fall: got %h expected %h t=%0t", fall, m_fall, $time); end
        checks++;
        if (changed !== m_chg) begin errors++; $display("FAIL model_changed: got %b expected %b t=%0t", changed, m_chg, $time); end
        checks++;
        if (out_b !== RV_B || rise_b !== '0 || fall_b !== '0 || changed_b !== 1'b0) begin
            errors++;
            $display("FAIL resetval_quiet: out=%h rise=%h fall=%h chg=%b expected out=%h no pulses t=%0t",
                     out_b, rise_b, fall_b, changed_b, RV_B, $time);
        end
    endtask

    task automatic settle(input logic [W-1:0] v);
        in = v;
        for (int k = 0; k < ST + F + 2; k++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; in = '0;
        tick(); tick();
        checks++;
        if (out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h rise=%h fall=%h chg=%b expected all zero", out, rise, fall, changed);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_release_quiet: out=%h expected 00", out); end
    endtask

    task automatic test_basic();
        in = 8'h01;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e < 5) begin
                checks++;
                if (out !== 8'h00) begin errors++; $display("FAIL basic_early e=%0d: out=%h expected 00", e, out); end
            end else if (e == 5) begin
                checks++;
                if (out !== 8'h01 || rise !== 8'h01 || changed !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_edge5: out=%h rise=%h chg=%b expected 01 01 1", out, rise, changed);
                end
            end else if (e == 6) begin
                checks++;
                if (rise !== 8'h00 || changed !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_pulse_width: rise=%h chg=%b expected 00 0", rise, changed);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int len;
        settle(8'h00);
        len = $urandom_range(1, F - 1);
        in = 8'h08;
        for (int k = 0; k < len; k++) tick();
        in = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin
                errors++;
                $display("FAIL glitch len=%0d: out=%h rise=%h fall=%h expected all 00", len, out, rise, fall);
            end
        end
    endtask

    task automatic test_fall();
        int nfall, nchg;
        settle(8'hFF);
        in = 8'h0F;
        nfall = 0; nchg = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (fall !== 8'h00) begin
                nfall++;
                checks++;
                if (fall !== 8'hF0) begin errors++; $display("FAIL fall_value: fall=%h expected f0", fall); end
            end
            if (changed) nchg++;
        end
        checks++;
        if (nfall != 1 || nchg != 1 || out !== 8'h0F) begin
            errors++;
            $display("FAIL fall_summary: falls=%0d chg=%0d out=%h expected 1 1 0f", nfall, nchg, out);
        end
    endtask

    task automatic test_hold();
        int nrise;
        settle(8'h00);
        hold = 1'b1;
        in = 8'h80;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen: out=%h rise=%h fall=%h chg=%b expected 00 quiet", out, rise, fall, changed);
            end
        end
        hold = 1'b0;
        nrise = 0;
        for (int k = 0; k < F + 3; k++) begin
            tick();
            if (rise !== 8'h00) begin
                nrise++;
                checks++;
                if (rise !== 8'h80) begin errors++; $display("FAIL hold_rise_value: rise=%h expected 80", rise); end
            end
            if (k == F - 1) begin
                checks++;
                if (out !== 8'h80) begin errors++; $display("FAIL hold_resume: out=%h expected 80", out); end
            end
        end
        checks++;
        if (nrise != 1) begin errors++; $display("FAIL hold_rise_count: got %0d expected 1", nrise); end
    endtask

    task automatic test_reset_mid();
        settle(8'h00);
        in = 8'h01;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: out=%h rise=%h fall=%h chg=%b expected all zero", out, rise, fall, changed);
        end
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e < 5) begin
                checks++;
                if (out !== 8'h00 || rise !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_mid_early e=%0d: out=%h rise=%h expected 00 00", e, out, rise);
                end
            end else if (e == 5) begin
                checks++;
                if (out !== 8'h01 || rise !== 8'h01) begin
                    errors++;
                    $display("FAIL reset_mid_latency: out=%h rise=%h expected 01 01", out, rise);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) in = W'($urandom);
            hold = ($urandom_range(0, 9) == 0);
            tick();
        end
        hold = 1'b0;
        settle(in);
    endtask

    task automatic test_reset_val();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        settle(8'h00);
        checks++;
        if (out_b !== RV_B) begin errors++; $display("FAIL resetval_out: got %h expected %h", out_b, RV_B); end
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; in = '0;
        hold_b = 1'b0; in_b = RV_B;
        model_reset();
        test_reset();
        test_basic();
        test_glitch();
        test_fall();
        test_hold();
        test_reset_mid();
        test_random();
        test_reset_val();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 8, number of independent channels (bits); SHALL be >= 1.
REQ-002 Parameter STAGES, default 2, synchronizer flops per channel; SHALL be >= 2.
REQ-003 Parameter FILTER, default 4, consecutive destination cycles a new level must persist before acceptance; SHALL be >= 1.
REQ-004 Parameter RESET_VAL, default 0 (WIDTH bits), reset level of every sync stage and of out.
REQ-005 clk  input  1  destination-domain clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in  input  WIDTH  asynchronous level signals from a foreign domain.
REQ-008 hold  input  1  synchronous; freezes filter state and outputs while high.
REQ-009 out  output  WIDTH  synchronized, debounced level per channel.
REQ-010 rise  output  WIDTH  one-cycle pulse per channel when out goes 0->1.
REQ-011 fall  output  WIDTH  one-cycle pulse per channel when out goes 1->0.
REQ-012 changed  output  1  one-cycle pulse when any bit of out changed this cycle.

Function
REQ-013 Each channel SHALL pass in[i] through a STAGES-deep flop chain; s[i] is the last stage.
REQ-014 Each channel SHALL hold a counter of width clog2(FILTER) (min 1 bit), range 0..FILTER-1.
REQ-015 When hold=0 and s[i]==out[i], the counter SHALL clear to 0; no output change.
REQ-016 When hold=0, s[i]!=out[i] and counter<FILTER-1, the counter SHALL increment.
REQ-017 When hold=0, s[i]!=out[i] and counter==FILTER-1, out[i] SHALL take s[i] at that edge and the counter SHALL clear.
REQ-018 A level change on in[i] sampled at edge k and held stable SHALL appear on out[i] after edge k+STAGES-1+FILTER; FILTER=1 gives plain STAGES+1 latency.
REQ-019 Any pulse on s[i] shorter than FILTER cycles SHALL not alter out[i] and SHALL generate no rise/fall.
REQ-020 rise[i]/fall[i] SHALL be registered, asserted for exactly the cycle following the edge at which out[i] changes, i.e. coincident with the new out value.
REQ-021 changed SHALL be registered, equal to OR of all rise and fall bits in the same cycle.
REQ-022 When hold=1, counters and out SHALL keep their values, rise/fall/changed SHALL be 0; the sync chain SHALL keep shifting.
REQ-023 On hold deassertion, filtering SHALL resume from the held counter values without reset.
REQ-024 Simultaneous changes on multiple channels SHALL be filtered independently; changed SHALL be a single pulse per cycle.
REQ-025 Counter SHALL never exceed FILTER-1 (no wrap).

Reset
REQ-026 rst_n low SHALL immediately force all sync stages and out to RESET_VAL, counters to 0, rise/fall/changed to 0.
REQ-027 Reset asserted mid-filter SHALL discard the partial count; no edge pulse SHALL be generated by reset entry or exit.
REQ-028 After release with in==RESET_VAL, no output SHALL change.

Structure
REQ-029 Package sync_pkg SHALL hold the clog2 function and the default parameter constants.
REQ-030 Sub-module sync_filter_ch SHALL implement one channel (chain, counter, out bit, rise/fall); sync_filter SHALL instantiate WIDTH copies via generate and OR-reduce for changed.

Verification
REQ-031 WIDTH=8, STAGES=2, FILTER=4, RESET_VAL=0: in 0x00->0x01 at edge 0, held -> out=0x01 and rise=0x01 for one cycle after edge 5; changed=1 same cycle.
REQ-032 Same config: 3-cycle glitch in[3]=1 -> out, rise, fall stay 0 throughout.
REQ-033 Same config: in=0xFF then 0x0F, held -> fall=0xF0 single cycle, out=0x0F, changed single pulse.
REQ-034 hold=1 during stable 0x00->0x80 transition for 10 cycles -> out stays 0x00, no pulses; hold=0 -> out=0x80 within FILTER cycles, one rise[7] pulse.
REQ-035 rst_n low for 1 cycle after counter reaches 2 on in[0] -> out=RESET_VAL, no pulse; after release with in[0] still 1, full STAGES-1+FILTER latency observed again.
REQ-036 RESET_VAL=0xA5, in=0xA5 across reset release -> out=0xA5, no rise/fall/changed ever asserted.
